// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmitter and receiver.
// Transmit FSM states and the bit-period calculation used by both directions.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Truncating division: the line runs slightly fast when CLK_FREQ is not a multiple of BAUD.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered pointers/count/flags; head is visible combinationally on dout.
// Writes while full and reads while empty are ignored; one-cycle write-to-visible latency.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [UART_DATA_BITS-1:0]     din,
    input  logic                          rd_en,
    output logic [UART_DATA_BITS-1:0]     dout,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic                      w_wr;
    logic                      w_rd;
    logic [CW-1:0]             w_count_nxt;

    assign w_wr = wr_en && !full;
    assign w_rd = rd_en && !empty;
    assign dout = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = count;
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = count + 1'b1;
            2'b01:   w_count_nxt = count - 1'b1;
            default: w_count_nxt = count;
        endcase
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            count <= w_count_nxt;
            full  <= (w_count_nxt == CW'(DEPTH));
            empty <= (w_count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1/8E1/8O1 serialiser, LSB first.
// tx falls one edge after a write into an idle, empty buffer; writes while full are dropped.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    din,
    input  logic                          wr_en,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx,
    output logic                          busy,
    output logic                          done
);
    localparam int              CPB       = clks_per_bit(CLK_FREQ, BAUD);
    localparam int              CW        = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CPB - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 r_state;
    tx_state_t                 w_state_nxt;
    logic [CW-1:0]             r_baud_cnt;
    logic [CW-1:0]             w_baud_nxt;
    logic [2:0]                r_bit_idx;
    logic [2:0]                w_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      r_parity;
    logic                      w_parity_nxt;
    logic                      r_tx;
    logic                      w_tx_nxt;
    logic                      w_pop;
    logic                      w_done;
    logic                      w_bit_end;
    logic                      w_fifo_empty;
    logic [UART_DATA_BITS-1:0] w_fifo_dout;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (din),
        .rd_en (w_pop),
        .dout  (w_fifo_dout),
        .count (fifo_count),
        .full  (full),
        .empty (w_fifo_empty)
    );

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud_cnt + 1'b1;
        w_bit_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_pop        = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    w_done     = 1'b1;
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_baud_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase

        // Parity is latched at pop because the shift register is consumed during DATA.
        if (w_pop) begin
            w_shift_nxt  = w_fifo_dout;
            w_parity_nxt = (^w_fifo_dout) ^ (PARITY_ODD != 0);
        end

        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = w_parity_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != IDLE);
    assign done = w_done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: directed and random bytes decoded off tx at bit centres against a frame model.
module tb_uart_tx_buffered;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 90;
    localparam int C        = CLK_FREQ / BAUD;
    localparam int DEPTH    = 8;
    localparam int NW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    din;
    logic          wr_en;
    logic          wr_en_p;

    logic          full, tx, busy, done;
    logic [NW-1:0] fifo_count;
    logic          full_e, tx_e, busy_e, done_e;
    logic [NW-1:0] cnt_e;
    logic          full_o, tx_o, busy_o, done_o;
    logic [NW-1:0] cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
                       .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
        .fifo_count(fifo_count), .tx(tx), .busy(busy), .done(done));

    uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
                       .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en_p), .full(full_e),
        .fifo_count(cnt_e), .tx(tx_e), .busy(busy_e), .done(done_e));

    uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
                       .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en_p), .full(full_o),
        .fifo_count(cnt_o), .tx(tx_o), .busy(busy_o), .done(done_o));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot i of a frame: start, 8 data LSB first, optional parity, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int i, input bit par, input bit odd);
        int v;
        if (i == 0) return 1'b0;
        if (i <= 8) begin
            v = int'(b) >> (i - 1);
            return v[0];
        end
        if (par && i == 9) begin
            v = ($countones(b) + int'(odd)) % 2;
            return v[0];
        end
        return 1'b1;
    endfunction

    // Called on the first negedge after the start edge; returns on the frame's last cycle.
    task automatic check_frame(input bit par, input logic [7:0] b, input string tag);
        int nb;
        int done_hits;
        int done_o_hits;
        int busy_low;
        logic done_last;
        nb = par ? 11 : 10;
        done_hits = 0;
        done_o_hits = 0;
        busy_low = 0;
        done_last = 1'b0;
        for (int k = 0; k < nb * C; k++) begin
            if (k > 0) @(negedge clk);
            if (k % C == C / 2) begin
                if (par) begin
                    chk($sformatf("%s_even_bit%0d", tag, k / C), 32'(tx_e), 32'(exp_bit(b, k / C, 1'b1, 1'b0)));
                    chk($sformatf("%s_odd_bit%0d", tag, k / C), 32'(tx_o), 32'(exp_bit(b, k / C, 1'b1, 1'b1)));
                end else begin
                    chk($sformatf("%s_bit%0d", tag, k / C), 32'(tx), 32'(exp_bit(b, k / C, 1'b0, 1'b0)));
                end
            end
            if (par ? done_e : done) done_hits++;
            if (done_o) done_o_hits++;
            if (!(par ? busy_e : busy)) busy_low++;
            if (k == nb * C - 1) done_last = par ? done_e : done;
        end
        chk({tag, "_done_count"}, 32'(done_hits), 32'd1);
        chk({tag, "_done_last_cycle"}, 32'(done_last), 32'd1);
        chk({tag, "_busy_low_cycles"}, 32'(busy_low), 32'd0);
        if (par) chk({tag, "_done_o_count"}, 32'(done_o_hits), 32'd1);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 40 * C) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, 32'(n < 40 * C), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_idle_tx"}, 32'(tx), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_count"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int occ;
        int nbytes;
        int gap;

        rst = 1'b1;
        din = 8'h00;
        wr_en = 1'b0;
        wr_en_p = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_tx_par", 32'(tx_e), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single byte, first-transmit latency; din changes after capture must not matter.
        din = 8'h55;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        din = 8'hFF;
        chk("lat_count_after_write", 32'(fifo_count), 32'd1);
        chk("lat_tx_still_high", 32'(tx), 32'd1);
        @(negedge clk);
        chk("lat_tx_low", 32'(tx), 32'd0);
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_count_after_pop", 32'(fifo_count), 32'd0);
        check_frame(1'b0, 8'h55, "f55");
        @(negedge clk);
        check_idle("f55");

        // Back-to-back frames from writes on consecutive cycles.
        din = 8'hA5;
        wr_en = 1'b1;
        @(negedge clk);
        din = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        check_frame(1'b0, 8'hA5, "fA5");
        @(negedge clk);
        chk("b2b_no_gap", 32'(tx), 32'd0);
        check_frame(1'b0, 8'h3C, "f3C");
        @(negedge clk);
        check_idle("b2b");

        // Fill the FIFO while a frame is in flight; the model accepts only while below DEPTH.
        din = 8'hEE;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        exp_q.delete();
        occ = 0;
        fork
            begin
                check_frame(1'b0, 8'hEE, "fEE");
                for (int j = 0; j < DEPTH; j++) begin
                    @(negedge clk);
                    chk($sformatf("full_b2b%0d", j), 32'(tx), 32'd0);
                    check_frame(1'b0, exp_q[j], $sformatf("full_f%0d", j));
                end
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < DEPTH + 1; i++) begin
                    din = 8'(i + 1);
                    wr_en = 1'b1;
                    if (occ < DEPTH) begin
                        occ++;
                        exp_q.push_back(8'(i + 1));
                    end
                    @(negedge clk);
                    chk($sformatf("full_count_w%0d", i), 32'(fifo_count), 32'(occ));
                    chk($sformatf("full_flag_w%0d", i), 32'(full), 32'(occ == DEPTH));
                end
                wr_en = 1'b0;
            end
        join
        chk("full_accepted", 32'(exp_q.size()), 32'(DEPTH));
        @(negedge clk);
        check_idle("full");

        // Random bytes with random write gaps.
        for (int r = 0; r < 2; r++) begin
            exp_q.delete();
            nbytes = $urandom_range(3, 7);
            for (int i = 0; i < nbytes; i++) exp_q.push_back(8'($urandom));
            fork
                begin
                    for (int i = 0; i < nbytes; i++) begin
                        din = exp_q[i];
                        wr_en = 1'b1;
                        @(negedge clk);
                        wr_en = 1'b0;
                        gap = $urandom_range(0, 2);
                        repeat (gap) @(negedge clk);
                    end
                end
                begin
                    wait_start($sformatf("rnd%0d", r));
                    for (int j = 0; j < nbytes; j++) begin
                        if (j > 0) begin
                            @(negedge clk);
                            chk($sformatf("rnd%0d_b2b%0d", r, j), 32'(tx), 32'd0);
                        end
                        check_frame(1'b0, exp_q[j], $sformatf("rnd%0d_f%0d", r, j));
                    end
                end
            join
            @(negedge clk);
            check_idle($sformatf("rnd%0d", r));
        end

        // Parity frames: 0x07 then a random byte, even and odd instances in lockstep.
        exp_q.delete();
        exp_q.push_back(8'h07);
        exp_q.push_back(8'($urandom));
        din = exp_q[0];
        wr_en_p = 1'b1;
        @(negedge clk);
        din = exp_q[1];
        @(negedge clk);
        wr_en_p = 1'b0;
        chk("par_start_even", 32'(tx_e), 32'd0);
        chk("par_start_odd", 32'(tx_o), 32'd0);
        check_frame(1'b1, exp_q[0], "par07");
        @(negedge clk);
        chk("par_b2b_even", 32'(tx_e), 32'd0);
        chk("par_b2b_odd", 32'(tx_o), 32'd0);
        check_frame(1'b1, exp_q[1], "parR");
        @(negedge clk);
        chk("par_idle_even", 32'(tx_e), 32'd1);
        chk("par_idle_busy", 32'(busy_e), 32'd0);

        // Asynchronous reset during data bit 3 of 0xF0, with a second byte waiting.
        din = 8'hF0;
        wr_en = 1'b1;
        @(negedge clk);
        din = 8'h11;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (4 * C + C / 2) @(negedge clk);
        chk("rst_mid_pre_tx", 32'(tx), 32'd0);
        chk("rst_mid_pre_count", 32'(fifo_count), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_tx_async", 32'(tx), 32'd1);
        chk("rst_mid_count", 32'(fifo_count), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        occ = 0;
        for (int k = 0; k < 12 * C; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) occ++;
        end
        chk("rst_mid_stays_idle", 32'(occ), 32'd0);
        chk("rst_mid_count_after", 32'(fifo_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
